// File: rtl/trace_uart_fifo.sv
// Register-mapped UART transmitter with a TX FIFO, overflow counter and idle interrupt.
// Frames are 1 start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits; no parity.
module trace_uart_fifo #(
   parameter int CLK_FREQ_HZ = 25_000_000,
   parameter int BAUDRATE    = 115_200,
   parameter int FIFO_DEPTH  = 16,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        io_write_valid_i,
   input  logic [11:0] io_addr_i,
   input  logic [31:0] io_wdata_i,
   output logic [31:0] io_rdata_o,
   output logic        uart_tx_o,
   output logic        busy_o,
   output logic        irq_o
);
   localparam int DIV = CLK_FREQ_HZ / BAUDRATE;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int CW  = $clog2(STOP_BITS * DIV);
   localparam int BW  = $clog2(DATA_BITS);

   if (DIV < 2) begin : g_bad_div
      $error("trace_uart_fifo: CLK_FREQ_HZ/BAUDRATE must be >= 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("trace_uart_fifo: FIFO_DEPTH must be a power of two in 2..256");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
      $error("trace_uart_fifo: DATA_BITS must be 5..8");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("trace_uart_fifo: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Reset asserts asynchronously everywhere but releases two clocks after rst_ni rises.
   logic [1:0] rst_sync;
   logic       rst_n;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rst_sync <= '0;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   logic wr_data, wr_ctrl, wr_ovf, flush;
   assign wr_data = io_write_valid_i && (io_addr_i == 12'h000);
   assign wr_ctrl = io_write_valid_i && (io_addr_i == 12'h004);
   assign wr_ovf  = io_write_valid_i && (io_addr_i == 12'h008);
   assign flush   = wr_ctrl && io_wdata_i[2];

   logic                 unused_wdata;
   assign unused_wdata = ^io_wdata_i;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        level;
   logic [7:0]           ovf_cnt;
   logic                 tx_en, irq_en;
   logic                 full, empty, push_ok, pop;

   assign full    = (level == LW'(FIFO_DEPTH));
   assign empty   = (level == '0);
   assign push_ok = wr_data && (!full || pop);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         ovf_cnt <= '0;
         tx_en   <= 1'b1;
         irq_en  <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      level <= level + LW'(1);
            else if (!push_ok && pop) level <= level - LW'(1);
         end
         if (wr_ovf)                                         ovf_cnt <= '0;
         else if (wr_data && full && !pop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
         if (wr_ctrl) begin
            tx_en  <= io_wdata_i[0];
            irq_en <= io_wdata_i[1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= io_wdata_i[DATA_BITS-1:0];
   end

   state_t               state, state_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic [BW-1:0]        bit_cnt, bit_d;
   logic [DATA_BITS-1:0] shreg, sh_d;
   logic                 tx_q, tx_d, can_start, cell_last;

   // A flush in the same cycle wins over a pop, so no frame starts from a discarded byte.
   assign can_start = tx_en && !empty && !flush;
   assign cell_last = (state == STOP) ? (cnt == CW'(STOP_BITS * DIV - 1)) : (cnt == CW'(DIV - 1));

   always_comb begin
      state_d = state;
      cnt_d   = cnt + CW'(1);
      bit_d   = bit_cnt;
      sh_d    = shreg;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (can_start) begin
               pop     = 1'b1;
               sh_d    = mem[rd_ptr];
               state_d = START;
            end
         end
         START: if (cell_last) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = DATA;
         end
         DATA: if (cell_last) begin
            cnt_d = '0;
            sh_d  = shreg >> 1;
            if (bit_cnt == BW'(DATA_BITS - 1)) state_d = STOP;
            else                               bit_d   = bit_cnt + BW'(1);
         end
         STOP: if (cell_last) begin
            cnt_d = '0;
            if (can_start) begin
               pop     = 1'b1;
               sh_d    = mem[rd_ptr];
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sh_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_cnt <= bit_d;
         shreg   <= sh_d;
         tx_q    <= tx_d;
      end
   end

   logic [31:0] status, rdata_d, rdata_q;
   logic        irq_q;
   assign status = {16'h0, 8'(level), 4'h0, (ovf_cnt != 8'h0), full, empty, busy_o};

   always_comb begin
      rdata_d = '0;
      case (io_addr_i)
         12'h000: rdata_d = status;
         12'h004: rdata_d = {30'h0, irq_en, tx_en};
         12'h008: rdata_d = {24'h0, ovf_cnt};
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         irq_q   <= irq_en && empty && (state == IDLE);
      end
   end

   assign busy_o     = (state != IDLE) || !empty;
   assign uart_tx_o  = tx_q;
   assign io_rdata_o = rdata_q;
   assign irq_o      = irq_q;
endmodule
